cdc_clear_phase_responder: RTL and testbench
============================================

# cdc_clear_phase_responder

Receiving end of the clear-sequence phase channel used by the CDC reset controller. It accepts phases of type `cdc_reset_ctrlr_pkg::clear_seq_phase_e` over a valid/ready channel, normally through a spill register, and executes each phase on the local side. Executing a phase means driving the isolation request, pulsing the clear signal, or releasing isolation. When the phase is complete, the block returns an acknowledgement carrying the same phase on a second valid/ready channel back to the initiator.

## Interface
- `ClearCycles`, default 2: number of cycles `clear_o` is held high per CLEAR phase; must be >= 1 (elaboration-time assertion).
- `CntWidth`, default `$clog2(ClearCycles+1)`: width of the clear counter; derived, do not override.

- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `phase_valid_i` in 1: incoming phase valid.
- `phase_ready_o` out 1: block can accept a phase.
- `phase_i` in `clear_seq_phase_e`: incoming phase (IDLE, ISOLATE, CLEAR, POST_CLEAR).
- `isolate_o` out 1: isolation request to local interface logic.
- `isolate_ack_i` in 1: local logic reports isolation is in effect (level).
- `clear_o` out 1: synchronous clear pulse to local state.
- `ack_valid_o` out 1: acknowledgement valid.
- `ack_ready_i` in 1: initiator accepts the acknowledgement.
- `ack_phase_o` out `clear_seq_phase_e`: phase being acknowledged.

## Operation
- FSM states: S_IDLE, S_WAIT_ISO, S_WAIT_DEISO, S_CLEAR, S_ACK.
- `phase_ready_o = (state == S_IDLE)`. All other outputs are registered.
- In S_IDLE, a handshake (`phase_valid_i & phase_ready_o`) latches `phase_i` into the ack phase register, then branches on the phase:
  - ISOLATE: set `isolate_o`, go to S_WAIT_ISO.
  - CLEAR: set `clear_o`, load counter = ClearCycles-1, go to S_CLEAR.
  - POST_CLEAR: clear `isolate_o`, go to S_WAIT_DEISO.
  - IDLE: go directly to S_ACK.
- S_WAIT_ISO: when `isolate_ack_i` = 1, go to S_ACK.
- S_WAIT_DEISO: when `isolate_ack_i` = 0, go to S_ACK.
- S_CLEAR: decrement the counter each cycle. When the counter = 0, drop `clear_o` and go to S_ACK.
- S_ACK:
  - `ack_valid_o` = 1 and `ack_phase_o` holds the latched phase.
  - Both stay stable until `ack_ready_i` = 1; that handshake returns the FSM to S_IDLE.
- `isolate_o` is sticky. Only POST_CLEAR or reset clears it. CLEAR and IDLE phases leave it unchanged.
- Phases that arrive out of order are executed anyway:
  - CLEAR without a prior ISOLATE still pulses `clear_o`.
  - ISOLATE while already isolated still waits for `isolate_ack_i` before acknowledging.
- While the FSM is outside S_IDLE, the block accepts no new phase. The initiator never has more than one outstanding phase.

## Timing
- Reset state: S_IDLE, and all of the following are 0: `isolate_o`, `clear_o`, `ack_valid_o`, `ack_phase_o` (= CLEAR_PHASE_IDLE), counter. `phase_ready_o` = 1 from the first cycle after reset deasserts. While `rst_i` is high, `phase_ready_o` = 0.
- Phase handshake in cycle N:
  - ISOLATE: `isolate_o` = 1 in N+1. If `isolate_ack_i` is first high in cycle M >= N+1, `ack_valid_o` = 1 in M+1.
  - CLEAR: `clear_o` = 1 in cycles N+1 .. N+ClearCycles. In cycle N+ClearCycles+1, `clear_o` = 0 and `ack_valid_o` = 1.
  - POST_CLEAR: `isolate_o` = 0 in N+1. If `isolate_ack_i` is first low in cycle M >= N+1, `ack_valid_o` = 1 in M+1.
  - IDLE: `ack_valid_o` = 1 in N+1.
- Ack handshake in cycle K: `ack_valid_o` = 0 and `phase_ready_o` = 1 in K+1. There is no same-cycle ack-to-accept bypass, so the minimum phase-to-phase spacing is 2 cycles.
- `isolate_ack_i` is sampled only from N+1 onward. A stale level in cycle N is ignored.
- Reset asserted mid-operation from any state:
  - The next cycle is in reset state.
  - `clear_o` and `isolate_o` drop immediately.
  - A pending ack is discarded, not replayed.
- `ack_valid_o` never deasserts without a handshake, except on reset.

## Test plan
- Reset, then ISOLATE with `isolate_ack_i` tied high 3 cycles after the handshake. Required: `isolate_o` = 1 at N+1, `ack_valid_o` = 1 at N+4 with `ack_phase_o` = ISOLATE, `phase_ready_o` = 0 until the ack handshake.
- ClearCycles=3, CLEAR handshake at cycle 10. Required: `clear_o` = 1 exactly in cycles 11-13, `ack_valid_o` = 1 at 14, `isolate_o` unchanged.
- Full sequence ISOLATE, CLEAR, POST_CLEAR, IDLE with `ack_ready_i` randomly stalled. Required:
  - acks return in order with matching phases;
  - `ack_phase_o` is stable while stalled;
  - `isolate_o` = 0 after POST_CLEAR once `isolate_ack_i` falls.
- IDLE phase with `ack_ready_i` = 1 constantly. Required: `ack_valid_o` one cycle after accept, `phase_ready_o` back to 1 the cycle after the ack, no other outputs toggle.
- Assert `rst_i` for 1 cycle during S_CLEAR (counter = 1), and separately during S_ACK. Required: next cycle `clear_o` = `isolate_o` = `ack_valid_o` = 0, and `phase_ready_o` = 1 after reset releases.
- CLEAR without prior ISOLATE, and ISOLATE while already isolated with `isolate_ack_i` already high. Required:
  - CLEAR: `clear_o` pulses for ClearCycles, then ack.
  - ISOLATE: ack at N+2.

Source files
------------

// File: rtl/cdc_clear_phase_responder.sv
// Receiving end of the clear-sequence phase channel: executes ISOLATE / CLEAR /
// POST_CLEAR / IDLE phases locally and returns an acknowledgement with the phase.
package cdc_reset_ctrlr_pkg;
  typedef enum logic [1:0] {
    CLEAR_PHASE_IDLE       = 2'd0,
    CLEAR_PHASE_ISOLATE    = 2'd1,
    CLEAR_PHASE_CLEAR      = 2'd2,
    CLEAR_PHASE_POST_CLEAR = 2'd3
  } clear_seq_phase_e;
endpackage

module cdc_clear_phase_responder
  import cdc_reset_ctrlr_pkg::*;
#(
  parameter int unsigned ClearCycles = 2,
  parameter int unsigned CntWidth    = $clog2(ClearCycles + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             phase_valid_i,
  output logic             phase_ready_o,
  input  clear_seq_phase_e phase_i,
  output logic             isolate_o,
  input  logic             isolate_ack_i,
  output logic             clear_o,
  output logic             ack_valid_o,
  input  logic             ack_ready_i,
  output clear_seq_phase_e ack_phase_o
);

  if (ClearCycles == 0) begin : g_bad_cfg
    $error("cdc_clear_phase_responder: ClearCycles must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ISO,
    S_WAIT_DEISO,
    S_CLEAR,
    S_ACK
  } state_e;

  state_e           r_state, w_state_nxt;
  logic             r_isolate, w_isolate_nxt;
  logic             r_clear, w_clear_nxt;
  logic             r_ack_valid, w_ack_valid_nxt;
  clear_seq_phase_e r_ack_phase, w_ack_phase_nxt;
  logic [CntWidth-1:0] r_cnt, w_cnt_nxt;

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign phase_ready_o = (r_state == S_IDLE) & ~rst_i;
  assign isolate_o     = r_isolate;
  assign clear_o       = r_clear;
  assign ack_valid_o   = r_ack_valid;
  assign ack_phase_o   = r_ack_phase;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_isolate   <= 1'b0;
      r_clear     <= 1'b0;
      r_ack_valid <= 1'b0;
      r_ack_phase <= CLEAR_PHASE_IDLE;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_isolate   <= w_isolate_nxt;
      r_clear     <= w_clear_nxt;
      r_ack_valid <= w_ack_valid_nxt;
      r_ack_phase <= w_ack_phase_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_isolate_nxt   = r_isolate;
    w_clear_nxt     = r_clear;
    w_ack_valid_nxt = r_ack_valid;
    w_ack_phase_nxt = r_ack_phase;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (phase_valid_i) begin
          w_ack_phase_nxt = phase_i;
          case (phase_i)
            CLEAR_PHASE_ISOLATE: begin
              w_isolate_nxt = 1'b1;
              w_state_nxt   = S_WAIT_ISO;
            end
            CLEAR_PHASE_CLEAR: begin
              w_clear_nxt = 1'b1;
              w_cnt_nxt   = CntWidth'(ClearCycles - 1);
              w_state_nxt = S_CLEAR;
            end
            CLEAR_PHASE_POST_CLEAR: begin
              w_isolate_nxt = 1'b0;
              w_state_nxt   = S_WAIT_DEISO;
            end
            default: begin
              w_ack_valid_nxt = 1'b1;
              w_state_nxt     = S_ACK;
            end
          endcase
        end
      end
      S_WAIT_ISO: begin
        if (isolate_ack_i) begin
          w_ack_valid_nxt = 1'b1;
          w_state_nxt     = S_ACK;
        end
      end
      S_WAIT_DEISO: begin
        if (!isolate_ack_i) begin
          w_ack_valid_nxt = 1'b1;
          w_state_nxt     = S_ACK;
        end
      end
      S_CLEAR: begin
        // Counter was loaded with ClearCycles-1, so clear_o spans ClearCycles cycles.
        if (r_cnt == '0) begin
          w_clear_nxt     = 1'b0;
          w_ack_valid_nxt = 1'b1;
          w_state_nxt     = S_ACK;
        end else begin
          w_cnt_nxt = r_cnt - CntWidth'(1);
        end
      end
      S_ACK: begin
        if (ack_ready_i) begin
          w_ack_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cdc_clear_phase_responder.sv
// Self-checking bench for cdc_clear_phase_responder: directed timing scenarios plus
// a randomized phase stream checked against a timing-rule reference model.
module tb_cdc_clear_phase_responder;
  import cdc_reset_ctrlr_pkg::*;

  localparam int CC = 3;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             phase_valid_i = 1'b0;
  logic             phase_ready_o;
  clear_seq_phase_e phase_i = CLEAR_PHASE_IDLE;
  logic             isolate_o;
  logic             isolate_ack_i = 1'b0;
  logic             clear_o;
  logic             ack_valid_o;
  logic             ack_ready_i = 1'b0;
  clear_seq_phase_e ack_phase_o;

  int checks = 0;
  int errors = 0;

  cdc_clear_phase_responder #(.ClearCycles(CC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .phase_valid_i(phase_valid_i), .phase_ready_o(phase_ready_o), .phase_i(phase_i),
    .isolate_o(isolate_o), .isolate_ack_i(isolate_ack_i), .clear_o(clear_o),
    .ack_valid_o(ack_valid_o), .ack_ready_i(ack_ready_i), .ack_phase_o(ack_phase_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one phase for a single cycle (caller has confirmed ready).
  task automatic send(input clear_seq_phase_e p);
    phase_valid_i = 1'b1;
    phase_i = p;
    step();
    phase_valid_i = 1'b0;
    phase_i = clear_seq_phase_e'($urandom_range(0, 3));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(); step();
    checks++; if (phase_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_held: got %b exp 0", phase_ready_o); end
    checks++; if ({isolate_o, clear_o, ack_valid_o} !== 3'b000) begin errors++; $display("FAIL rst_outputs: iso/clr/av got %b exp 000", {isolate_o, clear_o, ack_valid_o}); end
    checks++; if (ack_phase_o !== CLEAR_PHASE_IDLE) begin errors++; $display("FAIL rst_ack_phase: got %0d exp 0", ack_phase_o); end
    rst_i = 1'b0;
    step();
    checks++; if (phase_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_release: got %b exp 1", phase_ready_o); end
  endtask

  // ISOLATE with isolate_ack_i rising in cycle N+3 -> ack at N+4.
  task automatic test_isolate();
    isolate_ack_i = 1'b0;
    send(CLEAR_PHASE_ISOLATE);
    checks++; if (isolate_o !== 1'b1) begin errors++; $display("FAIL iso_set: got %b exp 1", isolate_o); end
    for (int k = 1; k <= 3; k++) begin
      checks++; if ({ack_valid_o, phase_ready_o} !== 2'b00) begin errors++; $display("FAIL iso_wait k=%0d: av/rdy got %b exp 00", k, {ack_valid_o, phase_ready_o}); end
      if (k == 3) isolate_ack_i = 1'b1;
      step();
    end
    checks++; if (ack_valid_o !== 1'b1 || ack_phase_o !== CLEAR_PHASE_ISOLATE) begin errors++; $display("FAIL iso_ack: av=%b ph=%0d exp av=1 ph=1", ack_valid_o, ack_phase_o); end
    checks++; if (phase_ready_o !== 1'b0) begin errors++; $display("FAIL iso_ack_ready: got %b exp 0", phase_ready_o); end
    ack_ready_i = 1'b1; step(); ack_ready_i = 1'b0;
    checks++; if ({ack_valid_o, phase_ready_o} !== 2'b01) begin errors++; $display("FAIL iso_done: av/rdy got %b exp 01", {ack_valid_o, phase_ready_o}); end
  endtask

  // CLEAR: clear_o high N+1..N+CC, ack at N+CC+1, isolate_o untouched.
  task automatic test_clear();
    logic iso_before;
    iso_before = isolate_o;
    send(CLEAR_PHASE_CLEAR);
    for (int k = 1; k <= CC; k++) begin
      checks++; if ({clear_o, ack_valid_o} !== 2'b10) begin errors++; $display("FAIL clr_pulse k=%0d: clr/av got %b exp 10", k, {clear_o, ack_valid_o}); end
      step();
    end
    checks++; if ({clear_o, ack_valid_o} !== 2'b01 || ack_phase_o !== CLEAR_PHASE_CLEAR) begin errors++; $display("FAIL clr_ack: clr/av got %b ph=%0d exp 01 ph=2", {clear_o, ack_valid_o}, ack_phase_o); end
    checks++; if (isolate_o !== iso_before) begin errors++; $display("FAIL clr_iso_keep: got %b exp %b", isolate_o, iso_before); end
    ack_ready_i = 1'b1; step(); ack_ready_i = 1'b0;
  endtask

  // IDLE with ack_ready_i held high: one-cycle turnaround, nothing else toggles.
  task automatic test_idle();
    logic iso_before;
    iso_before = isolate_o;
    ack_ready_i = 1'b1;
    send(CLEAR_PHASE_IDLE);
    checks++; if (ack_valid_o !== 1'b1 || ack_phase_o !== CLEAR_PHASE_IDLE) begin errors++; $display("FAIL idle_ack: av=%b ph=%0d exp av=1 ph=0", ack_valid_o, ack_phase_o); end
    checks++; if (isolate_o !== iso_before || clear_o !== 1'b0) begin errors++; $display("FAIL idle_quiet: iso=%b clr=%b exp iso=%b clr=0", isolate_o, clear_o, iso_before); end
    step();
    checks++; if ({ack_valid_o, phase_ready_o, clear_o} !== 3'b010 || isolate_o !== iso_before) begin errors++; $display("FAIL idle_back: av/rdy/clr got %b exp 010", {ack_valid_o, phase_ready_o, clear_o}); end
    ack_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    isolate_ack_i = 1'b1;
    send(CLEAR_PHASE_ISOLATE);
    step();
    ack_ready_i = 1'b1; step(); ack_ready_i = 1'b0;
    send(CLEAR_PHASE_CLEAR);
    step();  // counter now 1
    checks++; if ({clear_o, isolate_o} !== 2'b11) begin errors++; $display("FAIL rmid_pre: clr/iso got %b exp 11", {clear_o, isolate_o}); end
    rst_i = 1'b1; step();
    checks++; if ({clear_o, isolate_o, ack_valid_o, phase_ready_o} !== 4'b0000) begin errors++; $display("FAIL rmid_clear: clr/iso/av/rdy got %b exp 0000", {clear_o, isolate_o, ack_valid_o, phase_ready_o}); end
    rst_i = 1'b0; step();
    checks++; if ({phase_ready_o, clear_o, ack_valid_o} !== 3'b100) begin errors++; $display("FAIL rmid_clear_rel: rdy/clr/av got %b exp 100", {phase_ready_o, clear_o, ack_valid_o}); end
    send(CLEAR_PHASE_IDLE);
    checks++; if (ack_valid_o !== 1'b1) begin errors++; $display("FAIL rmid_ack_pre: got %b exp 1", ack_valid_o); end
    rst_i = 1'b1; step();
    checks++; if ({clear_o, isolate_o, ack_valid_o} !== 3'b000) begin errors++; $display("FAIL rmid_ack: clr/iso/av got %b exp 000", {clear_o, isolate_o, ack_valid_o}); end
    rst_i = 1'b0; step();
    checks++; if ({phase_ready_o, ack_valid_o} !== 2'b10) begin errors++; $display("FAIL rmid_ack_rel: rdy/av got %b exp 10", {phase_ready_o, ack_valid_o}); end
    step();
    checks++; if (ack_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_no_replay: got %b exp 0", ack_valid_o); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    isolate_ack_i = 1'b1;
    send(CLEAR_PHASE_CLEAR);
    for (int k = 1; k <= CC; k++) begin
      checks++; if ({clear_o, isolate_o, ack_valid_o} !== 3'b100) begin errors++; $display("FAIL ooo_clr k=%0d: clr/iso/av got %b exp 100", k, {clear_o, isolate_o, ack_valid_o}); end
      step();
    end
    checks++; if ({clear_o, ack_valid_o} !== 2'b01) begin errors++; $display("FAIL ooo_clr_ack: clr/av got %b exp 01", {clear_o, ack_valid_o}); end
    ack_ready_i = 1'b1; step(); ack_ready_i = 1'b0;
    // Two ISOLATEs back to back with the ack level already high: each acks at N+2.
    for (int r = 0; r < 2; r++) begin
      send(CLEAR_PHASE_ISOLATE);
      checks++; if ({isolate_o, ack_valid_o} !== 2'b10) begin errors++; $display("FAIL ooo_iso_n1 r=%0d: iso/av got %b exp 10", r, {isolate_o, ack_valid_o}); end
      step();
      checks++; if (ack_valid_o !== 1'b1 || ack_phase_o !== CLEAR_PHASE_ISOLATE) begin errors++; $display("FAIL ooo_iso_n2 r=%0d: av=%b ph=%0d exp av=1 ph=1", r, ack_valid_o, ack_phase_o); end
      ack_ready_i = 1'b1; step(); ack_ready_i = 1'b0;
    end
  endtask

  // Randomized stream (first four phases are the canonical sequence). The model
  // derives every output from the timing rules relative to the accept cycle.
  task automatic test_random_sequence();
    clear_seq_phase_e q[$];
    clear_seq_phase_e p, got;
    logic exp_iso;
    int   ack_at;
    bit   done;
    do_reset();
    exp_iso = 1'b0;
    for (int i = 0; i < 40; i++) begin
      case (i)
        0: p = CLEAR_PHASE_ISOLATE;
        1: p = CLEAR_PHASE_CLEAR;
        2: p = CLEAR_PHASE_POST_CLEAR;
        3: p = CLEAR_PHASE_IDLE;
        default: p = clear_seq_phase_e'($urandom_range(0, 3));
      endcase
      checks++; if (phase_ready_o !== 1'b1) begin errors++; $display("FAIL rnd_ready i=%0d: got %b exp 1", i, phase_ready_o); end
      isolate_ack_i = 1'($urandom_range(0, 1));  // stale level during accept
      q.push_back(p);
      send(p);
      if (p == CLEAR_PHASE_ISOLATE) exp_iso = 1'b1;
      if (p == CLEAR_PHASE_POST_CLEAR) exp_iso = 1'b0;
      ack_at = (p == CLEAR_PHASE_IDLE) ? 1 : (p == CLEAR_PHASE_CLEAR) ? CC + 1 : -1;
      done = 1'b0;
      for (int rel = 1; rel <= 60 && !done; rel++) begin
        checks++;
        if (isolate_o !== exp_iso || clear_o !== (p == CLEAR_PHASE_CLEAR && rel <= CC) ||
            ack_valid_o !== (ack_at > 0 && rel >= ack_at) || phase_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL rnd_out i=%0d rel=%0d ph=%0d: iso/clr/av/rdy got %b%b%b%b exp %b%b%b0", i, rel, p,
                   isolate_o, clear_o, ack_valid_o, phase_ready_o, exp_iso,
                   (p == CLEAR_PHASE_CLEAR && rel <= CC), (ack_at > 0 && rel >= ack_at));
        end
        if (ack_at > 0 && rel >= ack_at) begin
          checks++; if (ack_phase_o !== p) begin errors++; $display("FAIL rnd_ack_phase i=%0d rel=%0d: got %0d exp %0d", i, rel, ack_phase_o, p); end
          ack_ready_i = 1'($urandom_range(0, 1));
          if (ack_ready_i) begin
            got = ack_phase_o;
            step();
            ack_ready_i = 1'b0;
            checks++; if (got !== q.pop_front()) begin errors++; $display("FAIL rnd_order i=%0d: got %0d", i, got); end
            checks++; if ({ack_valid_o, phase_ready_o} !== 2'b01) begin errors++; $display("FAIL rnd_release i=%0d: av/rdy got %b exp 01", i, {ack_valid_o, phase_ready_o}); end
            done = 1'b1;
          end else begin
            step();
          end
        end else begin
          isolate_ack_i = 1'($urandom_range(0, 1));
          if (ack_at < 0 && p == CLEAR_PHASE_ISOLATE && isolate_ack_i) ack_at = rel + 1;
          if (ack_at < 0 && p == CLEAR_PHASE_POST_CLEAR && !isolate_ack_i) ack_at = rel + 1;
          step();
        end
      end
      if (!done) begin
        errors++;
        $display("FAIL rnd_timeout i=%0d: no ack handshake within 60 cycles", i);
        do_reset();
        exp_iso = 1'b0;
        q.delete();
      end
    end
  endtask

  initial begin
    test_reset();
    test_isolate();
    test_clear();
    test_idle();
    test_reset_mid();
    test_out_of_order();
    test_random_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
